gin_ctrl: RTL

Sequencer for the global input network (GIN). On a start pulse it programs the GIN scan chain, reading Y_LENGTH + X_LENGTH*Y_LENGTH tag IDs from a tag memory and shifting them in one per cycle with program asserted. It then streams a programmed number of {row_tag, col_tag, data} packets from an upstream valid/ready source into the GIN, obeying gin_ready back-pressure. It sits between the layer scheduler or tag memory and the gin block.

---
 rtl/gin_ctrl_if.sv | 42 ++++
 rtl/gin_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/gin_ctrl_if.sv
// Bundle between gin_ctrl and its neighbours: tag memory, GIN scan chain,
// upstream packet source, GIN data port and job control/status.
interface gin_ctrl_if #(
  parameter int BITWIDTH   = 16,
  parameter int TAG_LENGTH = 10,
  parameter int X_LENGTH   = 4,
  parameter int Y_LENGTH   = 4,
  parameter int CNT_WIDTH  = 16
);
  localparam int NUM_TAGS = Y_LENGTH + X_LENGTH * Y_LENGTH;
  localparam int ADDR_W   = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam int PKT_W    = 2 * TAG_LENGTH + BITWIDTH;

  logic                  i_start;
  logic [CNT_WIDTH-1:0]  i_num_packets;
  logic                  o_tag_rd_en;
  logic [ADDR_W-1:0]     o_tag_rd_addr;
  logic [TAG_LENGTH-1:0] i_tag_rd_data;
  logic                  o_program;
  logic [TAG_LENGTH-1:0] o_scan_tag_in;
  logic                  i_pkt_valid;
  logic                  o_pkt_ready;
  logic [PKT_W-1:0]      i_pkt_data;
  logic                  o_gin_enable;
  logic                  i_gin_ready;
  logic [PKT_W-1:0]      o_data_packet;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_error;

  modport master (
    input  i_start, i_num_packets, i_tag_rd_data, i_pkt_valid, i_pkt_data, i_gin_ready,
    output o_tag_rd_en, o_tag_rd_addr, o_program, o_scan_tag_in, o_pkt_ready,
           o_gin_enable, o_data_packet, o_busy, o_done, o_error
  );

  modport slave (
    output i_start, i_num_packets, i_tag_rd_data, i_pkt_valid, i_pkt_data, i_gin_ready,
    input  o_tag_rd_en, o_tag_rd_addr, o_program, o_scan_tag_in, o_pkt_ready,
           o_gin_enable, o_data_packet, o_busy, o_done, o_error
  );
endinterface

// File: rtl/gin_ctrl.sv
// GIN sequencer: programs the scan chain from tag memory, then streams packets.
// Optional back-pressure watchdog enabled by defining GIN_CTRL_WATCHDOG_EN.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | issuing tag memory reads, one address per cycle
// PROG   | draining read pipe into scan chain, then one gap cycle
// STREAM | forwarding upstream packets to the GIN
// DONE   | one-cycle done pulse
module gin_ctrl #(
  parameter int BITWIDTH   = 16,
  parameter int TAG_LENGTH = 10,
  parameter int X_LENGTH   = 4,
  parameter int Y_LENGTH   = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int TIMEOUT    = 255
) (
  input logic       clk,
  input logic       rstb,
  gin_ctrl_if.master bus
);
  localparam int NUM_TAGS = Y_LENGTH + X_LENGTH * Y_LENGTH;
  localparam int AW       = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam int PW       = 2 * TAG_LENGTH + BITWIDTH;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_TAGS - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PROG, S_STREAM, S_DONE} state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  r_accepted;
  logic [CNT_WIDTH-1:0]  r_sent;
  logic                  r_rd_en;
  logic [AW-1:0]         r_rd_addr;
  logic                  r_rd_pend;
  logic                  r_program;
  logic [TAG_LENGTH-1:0] r_scan;
  logic                  r_gin_en;
  logic [PW-1:0]         r_data;
  logic                  r_busy;
  logic                  r_done;

  logic w_pkt_ready;
  logic w_load;
  logic w_gin_acc;
  logic w_last_acc;
  logic w_timeout;

  // Upstream is gated once every packet of the job has been taken.
  assign w_pkt_ready = (r_state == S_STREAM) && (r_accepted != r_count) &&
                       (!r_gin_en || bus.i_gin_ready);
  assign w_load      = w_pkt_ready && bus.i_pkt_valid;
  assign w_gin_acc   = (r_state == S_STREAM) && r_gin_en && bus.i_gin_ready;
  assign w_last_acc  = w_gin_acc && ((r_sent + CNT_WIDTH'(1)) == r_count);

`ifdef GIN_CTRL_WATCHDOG_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] r_stall;
  logic          r_error;
  logic          w_stall;
  assign w_stall   = (r_state == S_STREAM) && r_gin_en && !bus.i_gin_ready;
  assign w_timeout = w_stall && (r_stall == SW'(TIMEOUT - 1));
  assign bus.o_error = r_error;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout   = 1'b0;
  assign bus.o_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_accepted <= '0;
      r_sent     <= '0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_pend  <= 1'b0;
      r_program  <= 1'b0;
      r_scan     <= '0;
      r_gin_en   <= 1'b0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef GIN_CTRL_WATCHDOG_EN
      r_stall    <= '0;
      r_error    <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_rd_pend <= r_rd_en;
      r_program <= r_rd_pend;
      r_scan    <= r_rd_pend ? bus.i_tag_rd_data : '0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_count    <= bus.i_num_packets;
            r_accepted <= '0;
            r_sent     <= '0;
            r_rd_en    <= 1'b1;
            r_rd_addr  <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_FETCH;
`ifdef GIN_CTRL_WATCHDOG_EN
            r_stall    <= '0;
            r_error    <= 1'b0;
`endif
          end
        end
        S_FETCH: begin
          if (r_rd_addr == LAST_ADDR) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_state   <= S_PROG;
          end else begin
            r_rd_addr <= r_rd_addr + AW'(1);
          end
        end
        S_PROG: begin
          // Both pipe stages empty means this is the gap cycle after the last shift.
          if (!r_rd_pend && !r_program) begin
            if (r_count == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (w_load) begin
            r_data     <= bus.i_pkt_data;
            r_gin_en   <= 1'b1;
            r_accepted <= r_accepted + CNT_WIDTH'(1);
          end else if (w_gin_acc) begin
            r_gin_en   <= 1'b0;
          end
          if (w_gin_acc) r_sent <= r_sent + CNT_WIDTH'(1);
`ifdef GIN_CTRL_WATCHDOG_EN
          if (w_gin_acc)    r_stall <= '0;
          else if (w_stall) r_stall <= r_stall + SW'(1);
          if (w_timeout) r_error <= 1'b1;
`endif
          if (w_last_acc || w_timeout) begin
            r_gin_en <= 1'b0;
            r_state  <= S_DONE;
            r_done   <= 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_tag_rd_en   = r_rd_en;
  assign bus.o_tag_rd_addr = r_rd_addr;
  assign bus.o_program     = r_program;
  assign bus.o_scan_tag_in = r_scan;
  assign bus.o_pkt_ready   = w_pkt_ready;
  assign bus.o_gin_enable  = r_gin_en;
  assign bus.o_data_packet = r_data;
  assign bus.o_busy        = r_busy;
  assign bus.o_done        = r_done;
endmodule
